// File: rtl/soc_event_queue_pkg.sv
// Shared types and defaults for the SoC event queue.
// Optional timestamp field enabled by SOC_EVENT_QUEUE_TIMESTAMP_EN.
package soc_event_queue_pkg;

  localparam int unsigned NB_EVENTS_DEFAULT  = 124;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 8;
  localparam int unsigned CNT_WIDTH_DEFAULT  = 2;
  localparam int unsigned TS_WIDTH_DEFAULT   = 32;
  localparam int unsigned ID_WIDTH_DEFAULT   = $clog2(NB_EVENTS_DEFAULT);

  typedef logic [ID_WIDTH_DEFAULT-1:0] event_id_t;

  typedef struct packed {
    event_id_t id;
`ifdef SOC_EVENT_QUEUE_TIMESTAMP_EN
    logic [TS_WIDTH_DEFAULT-1:0] ts;
`endif
  } entry_t;

  // Round-robin successor of idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/soc_event_rr_arb.sv
// N-way round-robin arbiter: one-hot grant plus index, search starts at the pointer.
module soc_event_rr_arb
  import soc_event_queue_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned IDXW = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N-1:0]    i_req,
  input  logic            i_en,
  output logic [N-1:0]    o_grant_c,
  output logic [IDXW-1:0] o_grant_idx_c,
  output logic            o_grant_valid_c
);

  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] w_idx;
  logic            w_found;
  int unsigned     w_cand;

  // First requester at or after the pointer, wrapping around the ring.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = 32'(r_ptr) + k;
      if (w_cand >= N) w_cand = w_cand - N;
      if (!w_found && i_req[IDXW'(w_cand)]) begin
        w_found = 1'b1;
        w_idx   = IDXW'(w_cand);
      end
    end
    o_grant_valid_c = w_found & i_en;
    o_grant_idx_c   = w_idx;
    o_grant_c       = '0;
    if (o_grant_valid_c) o_grant_c[w_idx] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (o_grant_valid_c) begin
      r_ptr <= IDXW'(rr_next(32'(w_idx), N));
    end
  end

endmodule

// File: rtl/soc_event_queue.sv
// Per-source event counters drained round-robin into a FIFO of event IDs.
// Define SOC_EVENT_QUEUE_TIMESTAMP_EN to tag each entry with its grant-cycle timestamp.
module soc_event_queue
  import soc_event_queue_pkg::*;
#(
  parameter  int unsigned NB_EVENTS  = NB_EVENTS_DEFAULT,
  parameter  int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter  int unsigned CNT_WIDTH  = CNT_WIDTH_DEFAULT,
`ifdef SOC_EVENT_QUEUE_TIMESTAMP_EN
  parameter  int unsigned TS_WIDTH   = TS_WIDTH_DEFAULT,
`endif
  localparam int unsigned ID_WIDTH   = $clog2(NB_EVENTS),
  localparam int unsigned LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NB_EVENTS-1:0] events_i,
  input  logic [NB_EVENTS-1:0] mask_i,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [ID_WIDTH-1:0]  evt_id_o,
`ifdef SOC_EVENT_QUEUE_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]  evt_ts_o,
`endif
  output logic [LVL_WIDTH-1:0] fifo_level_o,
  output logic                 ovf_o,
  output logic [ID_WIDTH-1:0]  ovf_id_o,
  input  logic                 ovf_clr_i
);

  localparam int unsigned          PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [LVL_WIDTH-1:0] LVL_FULL  = LVL_WIDTH'(FIFO_DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
`ifdef SOC_EVENT_QUEUE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;
`endif
  } fifo_entry_t;

  logic [CNT_WIDTH-1:0] r_cnt [NB_EVENTS];
  fifo_entry_t          r_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] r_wr_ptr;
  logic [PTR_WIDTH-1:0] r_rd_ptr;
  logic [LVL_WIDTH-1:0] r_level;
  logic                 r_evt_valid;
  fifo_entry_t          r_head;
  logic                 r_ovf;
  logic [ID_WIDTH-1:0]  r_ovf_id;
`ifdef SOC_EVENT_QUEUE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]  r_ts;
`endif

  logic [NB_EVENTS-1:0] w_inc;
  logic [NB_EVENTS-1:0] w_req;
  logic [NB_EVENTS-1:0] w_grant;
  logic [NB_EVENTS-1:0] w_lost;
  logic [ID_WIDTH-1:0]  w_grant_idx;
  logic                 w_grant_valid;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic [LVL_WIDTH-1:0] w_level_nxt;
  logic [PTR_WIDTH-1:0] w_rd_inc;
  fifo_entry_t          w_push_entry;
  fifo_entry_t          w_head_nxt;
  logic                 w_any_lost;
  logic [ID_WIDTH-1:0]  w_lost_idx;

  // Requests ignore the mask so already-counted events still drain.
  always_comb begin
    w_inc = events_i & mask_i;
    w_req = '0;
    for (int unsigned i = 0; i < NB_EVENTS; i++) begin
      w_req[i] = (r_cnt[i] != '0);
    end
  end

  always_comb begin
    w_lost = '0;
    for (int unsigned i = 0; i < NB_EVENTS; i++) begin
      w_lost[i] = w_inc[i] & ~w_grant[i] & (r_cnt[i] == CNT_MAX);
    end
  end

  // Lowest-index lost pulse is the one recorded.
  always_comb begin
    w_any_lost = 1'b0;
    w_lost_idx = '0;
    for (int unsigned i = 0; i < NB_EVENTS; i++) begin
      if (w_lost[i] && !w_any_lost) begin
        w_any_lost = 1'b1;
        w_lost_idx = ID_WIDTH'(i);
      end
    end
  end

  soc_event_rr_arb #(
    .N (NB_EVENTS)
  ) u_arb (
    .i_clk           (clk_i),
    .i_rst           (rst_i),
    .i_req           (w_req),
    .i_en            (~w_full),
    .o_grant_c       (w_grant),
    .o_grant_idx_c   (w_grant_idx),
    .o_grant_valid_c (w_grant_valid)
  );

  // Next FIFO state and next registered head entry.
  always_comb begin
    w_full          = (r_level == LVL_FULL);
    w_push          = w_grant_valid;
    w_pop           = r_evt_valid & evt_ready_i;
    w_level_nxt     = r_level + LVL_WIDTH'(w_push) - LVL_WIDTH'(w_pop);
    w_rd_inc        = r_rd_ptr + PTR_WIDTH'(1);
    w_push_entry    = '0;
    w_push_entry.id = w_grant_idx;
`ifdef SOC_EVENT_QUEUE_TIMESTAMP_EN
    w_push_entry.ts = r_ts;
`endif
    w_head_nxt = r_head;
    if (w_push && ((r_level == '0) || (w_pop && (r_level == LVL_WIDTH'(1))))) begin
      w_head_nxt = w_push_entry;
    end else if (w_pop && (r_level > LVL_WIDTH'(1))) begin
      w_head_nxt = r_mem[w_rd_inc];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_evt_valid <= 1'b0;
      r_head      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      if (w_pop)  r_rd_ptr <= w_rd_inc;
      r_level     <= w_level_nxt;
      r_evt_valid <= (w_level_nxt != '0);
      r_head      <= w_head_nxt;
    end
  end

  // Saturating per-source pending counters; simultaneous inc and dec cancel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NB_EVENTS; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB_EVENTS; i++) begin
        if (w_inc[i] && !w_grant[i]) begin
          if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
        end else if (!w_inc[i] && w_grant[i]) begin
          r_cnt[i] <= r_cnt[i] - CNT_WIDTH'(1);
        end
      end
    end
  end

  // A new loss beats a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovf    <= 1'b0;
      r_ovf_id <= '0;
    end else if (w_any_lost && (!r_ovf || ovf_clr_i)) begin
      r_ovf    <= 1'b1;
      r_ovf_id <= w_lost_idx;
    end else if (ovf_clr_i) begin
      r_ovf    <= 1'b0;
      r_ovf_id <= '0;
    end
  end

`ifdef SOC_EVENT_QUEUE_TIMESTAMP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) r_ts <= '0;
    else       r_ts <= r_ts + TS_WIDTH'(1);
  end

  assign evt_ts_o = r_head.ts;
`endif

  assign evt_valid_o  = r_evt_valid;
  assign evt_id_o     = r_head.id;
  assign fifo_level_o = r_level;
  assign ovf_o        = r_ovf;
  assign ovf_id_o     = r_ovf_id;

endmodule
